// File: rtl/mpeg_motion_vector_encoder.sv
// MPEG-2 motion-vector encoder: wrapped delta, motion_code/residual, Table B-10 VLC packing.
// Optional build macro MV_ENC_BITCNT_EN adds a running emitted-bit counter (bit_count port).
module mpeg_motion_vector_encoder #(
  parameter int VEC_W      = 16,
  parameter int MAX_R_SIZE = 8,
  parameter int OUT_W      = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [VEC_W-1:0] vec,
  input  logic signed [VEC_W-1:0] pred,
  input  logic [3:0]              r_size,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_bits,
  output logic [4:0]              out_len,
  output logic signed [VEC_W-1:0] pred_out
`ifdef MV_ENC_BITCNT_EN
  ,
  output logic [31:0]             bit_count
`endif
);

  // Two guard bits: vec-pred needs one, and the single wrap correction/pred+d sum needs another.
  localparam int DW = VEC_W + 2;
  localparam logic signed [DW-1:0] ONE_S = DW'(1);

  typedef enum logic [1:0] {S_IDLE, S_DELTA, S_CODE, S_EMIT} state_t;

  state_t                  state_q;
  logic signed [VEC_W-1:0] vec_q, pred_q;
  logic [3:0]              r_q, r_clamp;
  logic signed [DW-1:0]    d_q, d_d, d_raw;
  logic                    in_ready_q, out_valid_q;
  logic [OUT_W-1:0]        out_bits_q, out_bits_d;
  logic [4:0]              out_len_q, out_len_d;
  logic signed [VEC_W-1:0] pred_out_q, pred_out_d;

  logic signed [DW-1:0]    f_s, high_s, low_s, range_s, psum, psum_w;
  logic [DW-1:0]           abs_d, abs_m1, mc_w, res_w, fmask;
  logic [4:0]              mc;
  logic [9:0]              vlc_val;
  logic [3:0]              vlc_len;

  // Clamp incoming r_size to the largest supported value.
  always_comb begin
    r_clamp = (r_size > 4'(MAX_R_SIZE)) ? 4'(MAX_R_SIZE) : r_size;
  end

  // Legal vector window [low, high] and its span for the latched r.
  always_comb begin
    f_s     = ONE_S <<< r_q;
    high_s  = (f_s <<< 4) - ONE_S;
    low_s   = -(f_s <<< 4);
    range_s = f_s <<< 5;
  end

  // Raw delta with exactly one modular correction back toward the window.
  always_comb begin
    d_raw = $signed({{2{vec_q[VEC_W-1]}}, vec_q}) - $signed({{2{pred_q[VEC_W-1]}}, pred_q});
    if (d_raw > high_s)
      d_d = d_raw - range_s;
    else if (d_raw < low_s)
      d_d = d_raw + range_s;
    else
      d_d = d_raw;
  end

  // motion_code, residual, VLC lookup and packing, plus updated predictor.
  always_comb begin
    abs_d  = d_q[DW-1] ? $unsigned(-d_q) : $unsigned(d_q);
    abs_m1 = abs_d - DW'(1);
    fmask  = $unsigned(f_s) - DW'(1);
    mc_w   = abs_d;
    res_w  = '0;
    if ((abs_d != '0) && (r_q != 4'd0)) begin
      mc_w  = (abs_m1 >> r_q) + DW'(1);
      res_w = abs_m1 & fmask;
    end
    // mc cannot exceed 16 for in-window operands; saturate so stray inputs still give a legal code.
    mc = (mc_w > DW'(16)) ? 5'd16 : mc_w[4:0];

    case (mc)
      5'd1:    begin vlc_val = 10'b0000000001; vlc_len = 4'd2;  end
      5'd2:    begin vlc_val = 10'b0000000001; vlc_len = 4'd3;  end
      5'd3:    begin vlc_val = 10'b0000000001; vlc_len = 4'd4;  end
      5'd4:    begin vlc_val = 10'b0000000011; vlc_len = 4'd6;  end
      5'd5:    begin vlc_val = 10'b0000000101; vlc_len = 4'd7;  end
      5'd6:    begin vlc_val = 10'b0000000100; vlc_len = 4'd7;  end
      5'd7:    begin vlc_val = 10'b0000000011; vlc_len = 4'd7;  end
      5'd8:    begin vlc_val = 10'b0000001011; vlc_len = 4'd9;  end
      5'd9:    begin vlc_val = 10'b0000001010; vlc_len = 4'd9;  end
      5'd10:   begin vlc_val = 10'b0000001001; vlc_len = 4'd9;  end
      5'd11:   begin vlc_val = 10'b0000010001; vlc_len = 4'd10; end
      5'd12:   begin vlc_val = 10'b0000010000; vlc_len = 4'd10; end
      5'd13:   begin vlc_val = 10'b0000001111; vlc_len = 4'd10; end
      5'd14:   begin vlc_val = 10'b0000001110; vlc_len = 4'd10; end
      5'd15:   begin vlc_val = 10'b0000001101; vlc_len = 4'd10; end
      5'd16:   begin vlc_val = 10'b0000001100; vlc_len = 4'd10; end
      default: begin vlc_val = 10'b0000000001; vlc_len = 4'd1;  end
    endcase

    if (mc == 5'd0) begin
      out_bits_d = OUT_W'(1);
      out_len_d  = 5'd1;
    end else begin
      // {vlc, sign} then r residual bits; res_w is zero when r is zero.
      out_bits_d = (OUT_W'({vlc_val, d_q[DW-1]}) << r_q) | OUT_W'(res_w);
      out_len_d  = 5'(vlc_len) + 5'd1 + 5'(r_q);
    end

    psum = $signed({{2{pred_q[VEC_W-1]}}, pred_q}) + d_q;
    if (psum > high_s)
      psum_w = psum - range_s;
    else if (psum < low_s)
      psum_w = psum + range_s;
    else
      psum_w = psum;
    pred_out_d = psum_w[VEC_W-1:0];
  end

  // Sequencer IDLE -> DELTA -> CODE -> EMIT with registered handshake and output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      pred_q      <= '0;
      r_q         <= '0;
      d_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_len_q   <= '0;
      pred_out_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            vec_q      <= vec;
            pred_q     <= pred;
            r_q        <= r_clamp;
            in_ready_q <= 1'b0;
            state_q    <= S_DELTA;
          end
        end
        S_DELTA: begin
          d_q     <= d_d;
          state_q <= S_CODE;
        end
        S_CODE: begin
          out_bits_q  <= out_bits_d;
          out_len_q   <= out_len_d;
          pred_out_q  <= pred_out_d;
          out_valid_q <= 1'b1;
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;
  assign out_len   = out_len_q;
  assign pred_out  = pred_out_q;

`ifdef MV_ENC_BITCNT_EN
  logic [31:0] bit_count_q, bit_count_d;

  // Accumulate emitted length on every accepted word; wraps naturally at 2^32.
  always_comb begin
    bit_count_d = bit_count_q;
    if (out_valid_q && out_ready)
      bit_count_d = bit_count_q + 32'(out_len_q);
  end

  // Counter register, cleared with the rest of the block.
  always_ff @(posedge clk) begin
    if (rst)
      bit_count_q <= '0;
    else
      bit_count_q <= bit_count_d;
  end

  assign bit_count = bit_count_q;
`else
  // Counter not built.
`endif

endmodule

// File: tb/tb_mpeg_motion_vector_encoder.sv
// Bench for mpeg_motion_vector_encoder: directed cases plus random vectors vs. a string-based VLC model.
module tb_mpeg_motion_vector_encoder;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] vec;
  logic signed [15:0] pred;
  logic [3:0]         r_size;
  logic               out_valid;
  logic               out_ready;
  logic [23:0]        out_bits;
  logic [4:0]         out_len;
  logic [15:0]        pred_out;
`ifdef MV_ENC_BITCNT_EN
  logic [31:0]        bit_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  longint exp_bitcnt = 0;

  string vlc_tab [0:16] = '{"1", "01", "001", "0001", "000011", "0000101", "0000100",
                            "0000011", "000001011", "000001010", "000001001", "0000010001",
                            "0000010000", "0000001111", "0000001110", "0000001101", "0000001100"};

  mpeg_motion_vector_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec       (vec),
    .pred      (pred),
    .r_size    (r_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_len   (out_len),
    .pred_out  (pred_out)
`ifdef MV_ENC_BITCNT_EN
    ,
    .bit_count (bit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: integer arithmetic, code assembled as a character string of bits.
  function automatic void model(input int v, input int p, input int rs,
                                output logic [23:0] bits, output int len, output int po);
    int r, f, hi, lo, rng, d, ad, mc, res;
    string s;
    r   = (rs > 8) ? 8 : rs;
    f   = 1 << r;
    hi  = 16 * f - 1;
    lo  = -16 * f;
    rng = 32 * f;
    d   = v - p;
    if (d > hi) d = d - rng;
    else if (d < lo) d = d + rng;
    ad = (d < 0) ? -d : d;
    if (d == 0 || r == 0) begin
      mc  = ad;
      res = 0;
    end else begin
      mc  = (ad - 1) / f + 1;
      res = (ad - 1) % f;
    end
    s = vlc_tab[mc];
    if (mc != 0) begin
      if (d < 0) s = {s, "1"};
      else       s = {s, "0"};
      for (int i = r - 1; i >= 0; i--) begin
        if (((res >> i) & 1) == 1) s = {s, "1"};
        else                       s = {s, "0"};
      end
    end
    bits = '0;
    for (int i = 0; i < s.len(); i++)
      bits = {bits[22:0], (s.getc(i) == "1")};
    len = s.len();
    po = p + d;
    if (po > hi) po = po - rng;
    else if (po < lo) po = po + rng;
  endfunction

  // One full transaction: accept, latency, output word, optional stall, handshake.
  task automatic run_vec(input int v, input int p, input int rs,
                         input logic [23:0] eb, input int el, input int ep, input int hold);
    int n;
    int lat;
    logic [23:0] bits_hold;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_eq("in_ready_idle", {63'd0, in_ready}, 64'd1);
    vec      = 16'(v);
    pred     = 16'(p);
    r_size   = 4'(rs);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Keep pushing junk while busy; it must be ignored.
    vec    = 16'($urandom);
    pred   = 16'($urandom);
    r_size = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      chk_eq("in_ready_busy", {63'd0, in_ready}, 64'd0);
    end while (!out_valid && lat < 10);
    chk_eq("latency", 64'(lat), 64'd3);
    chk_eq("out_bits", {40'd0, out_bits}, {40'd0, eb});
    chk_eq("out_len", {59'd0, out_len}, 64'(el));
    chk_eq("pred_out", {48'd0, pred_out}, {48'd0, 16'(ep)});
    bits_hold = out_bits;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk_eq("stall_valid", {63'd0, out_valid}, 64'd1);
      chk_eq("stall_bits", {40'd0, out_bits}, {40'd0, bits_hold});
      chk_eq("stall_pred", {48'd0, pred_out}, {48'd0, 16'(ep)});
      chk_eq("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_bitcnt = exp_bitcnt + el;
    @(negedge clk);
    chk_eq("post_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("post_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef MV_ENC_BITCNT_EN
    chk_eq("bit_count", {32'd0, bit_count}, {32'd0, 32'(exp_bitcnt)});
`endif
  endtask

  initial begin
    logic [23:0] eb;
    int el, ep, r, f, v, p, rs;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    vec = '0;
    pred = '0;
    r_size = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("rst_out_bits", {40'd0, out_bits}, 64'd0);
    chk_eq("rst_out_len", {59'd0, out_len}, 64'd0);
    chk_eq("rst_pred_out", {48'd0, pred_out}, 64'd0);
`ifdef MV_ENC_BITCNT_EN
    chk_eq("rst_bit_count", {32'd0, bit_count}, 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_vec(3, 0, 0, 24'b00010, 5, 3, 0);
    run_vec(-5, 0, 1, 24'b000110, 6, -5, 0);
    run_vec(-10, 10, 0, 24'b00000100000, 11, -10, 0);
    run_vec(7, 7, 2, 24'b1, 1, 7, 0);
    run_vec(3, 0, 0, 24'b00010, 5, 3, 5);
    // Extremes of the widest window and an over-range r_size that must clamp to 8.
    model(4095, -4096, 8, eb, el, ep);
    run_vec(4095, -4096, 8, eb, el, ep, 1);
    model(-4096, 4095, 15, eb, el, ep);
    run_vec(-4096, 4095, 15, eb, el, ep, 0);
    model(-16, 15, 0, eb, el, ep);
    run_vec(-16, 15, 0, eb, el, ep, 0);

    for (int t = 0; t < 150; t++) begin
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      r  = (rs > 8) ? 8 : rs;
      f  = 1 << r;
      v  = int'($urandom_range(0, 32 * f - 1)) - 16 * f;
      p  = int'($urandom_range(0, 32 * f - 1)) - 16 * f;
      if ($urandom_range(0, 7) == 0) v = p;
      model(v, p, rs, eb, el, ep);
      run_vec(v, p, rs, eb, el, ep, int'($urandom_range(0, 2)));
    end

    // Abort a vector with reset while it sits in CODE.
    vec = 16'sd100;
    pred = -16'sd3;
    r_size = 4'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_bitcnt = 0;
    chk_eq("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk_eq("abort_out_bits", {40'd0, out_bits}, 64'd0);
    chk_eq("abort_out_len", {59'd0, out_len}, 64'd0);
    chk_eq("abort_pred_out", {48'd0, pred_out}, 64'd0);
`ifdef MV_ENC_BITCNT_EN
    chk_eq("abort_bit_count", {32'd0, bit_count}, 64'd0);
`endif
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_eq("abort_quiet", {63'd0, out_valid}, 64'd0);
    end
    model(-1, 1, 4, eb, el, ep);
    run_vec(-1, 1, 4, eb, el, ep, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
